// File: rtl/timer_countdown.sv
// rtl/timer_countdown.sv - settable hh:mm:ss countdown timer with alarm
// Define TIMER_RELOAD_EN for repeat mode: reload preset at zero with a one-clock alarm pulse.
module timer_countdown #(
  parameter int HOUR_MAX     = 99,
  parameter int DONE_SECONDS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        active,
  input  logic        btn_start,
  input  logic        btn_set,
  input  logic        btn_inc,
  input  logic        btn_dec,
  output logic [23:0] data_t,
  output logic [1:0]  setup_rezhim_t,
  output logic [23:0] setup_data_t,
  output logic        alarm,
  output logic        running
);

  localparam int DCW = $clog2(DONE_SECONDS + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [23:0]    preset_q, preset_d;
  logic [23:0]    data_q, data_d;
  logic [23:0]    sdata_q, sdata_d;
  logic [1:0]     field_q, field_d;
  logic           alarm_q, alarm_d;
  logic           running_q, running_d;
  logic [DCW-1:0] done_cnt_q, done_cnt_d;

  logic b_start, b_set, b_inc, b_dec;

  // Only the highest-priority button pulse survives.
  assign b_start = active & btn_start;
  assign b_set   = active & btn_set & ~btn_start;
  assign b_inc   = active & btn_inc & ~btn_start & ~btn_set;
  assign b_dec   = active & btn_dec & ~btn_start & ~btn_set & ~btn_inc;

  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] max);
    return (v == 8'd0 || v > max) ? max : v - 8'd1;
  endfunction

  function automatic logic [23:0] edit_field(input logic [23:0] t, input logic [1:0] f,
                                             input logic up);
    logic [7:0] h, m, s;
    {h, m, s} = t;
    case (f)
      2'd1:    h = up ? wrap_inc(h, 8'(HOUR_MAX)) : wrap_dec(h, 8'(HOUR_MAX));
      2'd2:    m = up ? wrap_inc(m, 8'd59) : wrap_dec(m, 8'd59);
      2'd3:    s = up ? wrap_inc(s, 8'd59) : wrap_dec(s, 8'd59);
      default: ;
    endcase
    return {h, m, s};
  endfunction

  // Caller guarantees t != 0, so the hour borrow never underflows.
  function automatic logic [23:0] dec_time(input logic [23:0] t);
    logic [7:0] h, m, s;
    {h, m, s} = t;
    if (s != 8'd0) begin
      s = s - 8'd1;
    end else begin
      s = 8'd59;
      if (m != 8'd0) begin
        m = m - 8'd1;
      end else begin
        m = 8'd59;
        h = h - 8'd1;
      end
    end
    return {h, m, s};
  endfunction

  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    data_d     = data_q;
    sdata_d    = sdata_q;
    field_d    = field_q;
    done_cnt_d = done_cnt_q;
    alarm_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (b_set) begin
          state_d = ST_SETUP;
          field_d = 2'd1;
          sdata_d = preset_q;
        end else if (b_start && data_q != 24'd0) begin
          state_d = ST_RUN;
        end
      end

      ST_SETUP: begin
        if (b_start) begin
          state_d = ST_IDLE;
          field_d = 2'd0;
        end else if (b_set) begin
          if (field_q == 2'd3) begin
            preset_d = sdata_q;
            data_d   = sdata_q;
            field_d  = 2'd0;
            state_d  = ST_IDLE;
          end else begin
            field_d = field_q + 2'd1;
          end
        end else if (b_inc) begin
          sdata_d = edit_field(sdata_q, field_q, 1'b1);
        end else if (b_dec) begin
          sdata_d = edit_field(sdata_q, field_q, 1'b0);
        end
      end

      ST_RUN: begin
        if (b_start) begin
          state_d = ST_PAUSE;
        end else if (tick_1hz) begin
          if (data_q == 24'd1) begin
`ifdef TIMER_RELOAD_EN
            data_d  = preset_q;
            alarm_d = 1'b1;
`else
            data_d     = 24'd0;
            state_d    = ST_DONE;
            done_cnt_d = '0;
            alarm_d    = 1'b1;
`endif
          end else begin
            data_d = dec_time(data_q);
          end
        end
      end

      ST_PAUSE: begin
        if (b_start) begin
          state_d = ST_RUN;
        end else if (b_set) begin
          state_d = ST_IDLE;
          data_d  = preset_q;
        end
      end

      ST_DONE: begin
        if (b_start || (tick_1hz && done_cnt_q == DCW'(DONE_SECONDS - 1))) begin
          state_d    = ST_IDLE;
          data_d     = preset_q;
          done_cnt_d = '0;
        end else begin
          alarm_d = 1'b1;
          if (tick_1hz) begin
            done_cnt_d = done_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        field_d = 2'd0;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      preset_q   <= '0;
      data_q     <= '0;
      sdata_q    <= '0;
      field_q    <= '0;
      alarm_q    <= 1'b0;
      running_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      data_q     <= data_d;
      sdata_q    <= sdata_d;
      field_q    <= field_d;
      alarm_q    <= alarm_d;
      running_q  <= running_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign data_t         = data_q;
  assign setup_rezhim_t = field_q;
  assign setup_data_t   = sdata_q;
  assign alarm          = alarm_q;
  assign running        = running_q;

endmodule

// File: tb/tb_timer_countdown.sv
// tb/tb_timer_countdown.sv - scoreboard bench for timer_countdown
// Reference model keeps time as total seconds; honours TIMER_RELOAD_EN.
module tb_timer_countdown;

  localparam int HOUR_MAX     = 99;
  localparam int DONE_SECONDS = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        active = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_set = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic [23:0] data_t;
  logic [1:0]  setup_rezhim_t;
  logic [23:0] setup_data_t;
  logic        alarm;
  logic        running;

  timer_countdown #(.HOUR_MAX(HOUR_MAX), .DONE_SECONDS(DONE_SECONDS)) dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .active(active),
    .btn_start(btn_start), .btn_set(btn_set), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .data_t(data_t), .setup_rezhim_t(setup_rezhim_t), .setup_data_t(setup_data_t),
    .alarm(alarm), .running(running)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] data;
    logic [1:0]  rez;
    logic [23:0] sdata;
    logic        alarm;
    logic        running;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  typedef enum int {M_IDLE, M_SETUP, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_preset = 0, m_value = 0, m_field = 0, m_done = 0;
  int      m_eh = 0, m_em = 0, m_es = 0;
  bit      m_alarm = 0;
  bit      rst_v = 1'b0;
  bit      act_v = 1'b1;

  function automatic logic [23:0] to_word(input int secs);
    logic [7:0] h, m, s;
    h = 8'(secs / 3600);
    m = 8'((secs / 60) % 60);
    s = 8'(secs % 60);
    return {h, m, s};
  endfunction

  task automatic bump(input int d);
    case (m_field)
      1: m_eh = (m_eh + d + HOUR_MAX + 1) % (HOUR_MAX + 1);
      2: m_em = (m_em + d + 60) % 60;
      3: m_es = (m_es + d + 60) % 60;
      default: ;
    endcase
  endtask

  task automatic model_step();
    int btn;
    if (!reset) begin
      m_state = M_IDLE; m_preset = 0; m_value = 0; m_field = 0; m_done = 0;
      m_eh = 0; m_em = 0; m_es = 0; m_alarm = 0;
    end else begin
      btn = !active ? 0 : btn_start ? 1 : btn_set ? 2 : btn_inc ? 3 : btn_dec ? 4 : 0;
      m_alarm = 0;
      case (m_state)
        M_IDLE: begin
          if (btn == 2) begin
            m_state = M_SETUP; m_field = 1;
            m_eh = m_preset / 3600; m_em = (m_preset / 60) % 60; m_es = m_preset % 60;
          end else if (btn == 1 && m_value != 0) begin
            m_state = M_RUN;
          end
        end
        M_SETUP: begin
          case (btn)
            1: begin m_field = 0; m_state = M_IDLE; end
            2: begin
              if (m_field == 3) begin
                m_preset = m_eh * 3600 + m_em * 60 + m_es;
                m_value = m_preset; m_field = 0; m_state = M_IDLE;
              end else begin
                m_field = m_field + 1;
              end
            end
            3: bump(1);
            4: bump(-1);
            default: ;
          endcase
        end
        M_RUN: begin
          if (btn == 1) begin
            m_state = M_PAUSE;
          end else if (tick_1hz) begin
            m_value = m_value - 1;
            if (m_value == 0) begin
`ifdef TIMER_RELOAD_EN
              m_value = m_preset; m_alarm = 1;
`else
              m_state = M_DONE; m_done = 0;
`endif
            end
          end
        end
        M_PAUSE: begin
          if (btn == 1) m_state = M_RUN;
          else if (btn == 2) begin m_state = M_IDLE; m_value = m_preset; end
        end
        M_DONE: begin
          if (btn == 1) begin
            m_state = M_IDLE; m_value = m_preset;
          end else if (tick_1hz) begin
            m_done = m_done + 1;
            if (m_done == DONE_SECONDS) begin m_state = M_IDLE; m_value = m_preset; end
          end
        end
        default: ;
      endcase
      if (m_state == M_DONE) m_alarm = 1;
    end
  endtask

  task automatic cyc(input bit t, input bit st, input bit se, input bit inc, input bit de);
    exp_t e;
    @(negedge clock);
    reset = rst_v; active = act_v;
    tick_1hz = t; btn_start = st; btn_set = se; btn_inc = inc; btn_dec = de;
    model_step();
    e.data = to_word(m_value);
    e.rez = 2'(m_field);
    e.sdata = {8'(m_eh), 8'(m_em), 8'(m_es)};
    e.alarm = m_alarm;
    e.running = (m_state == M_RUN);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_t", data_t, e.data);
        chk("setup_rezhim_t", 24'(setup_rezhim_t), 24'(e.rez));
        chk("setup_data_t", setup_data_t, e.sdata);
        chk("alarm", 24'(alarm), 24'(e.alarm));
        chk("running", 24'(running), 24'(e.running));
      end
    end
  end

  initial begin : stimulus
    rst_v = 0; idle(2); rst_v = 1; idle(1);
    // setup 00:01:05
    cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,0,0,1,0); cyc(0,0,1,0,0);
    for (int i = 0; i < 5; i++) cyc(0,0,0,1,0);
    cyc(0,0,1,0,0); idle(1);
    // run, then reset mid-run
    cyc(0,1,0,0,0);
    for (int i = 0; i < 3; i++) begin cyc(1,0,0,0,0); idle(1); end
    rst_v = 0; idle(2); rst_v = 1; idle(1);
    // wrap in setup: hour dec from 0, min dec/inc across 59/0, abort
    cyc(0,0,1,0,0); cyc(0,0,0,0,1); cyc(0,0,1,0,0); cyc(0,0,0,0,1); cyc(0,0,0,1,0);
    cyc(1,0,0,0,0); cyc(0,1,0,0,0); idle(1);
    // borrow from 01:00:00 and start coincident with tick
    rst_v = 0; idle(1); rst_v = 1;
    cyc(0,0,1,0,0); cyc(0,0,0,1,0); cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,0,1,0,0);
    cyc(0,1,0,0,0); cyc(1,0,0,0,0); cyc(1,1,0,0,0); cyc(1,0,0,0,0);
    cyc(0,1,0,0,0); cyc(1,0,0,0,0); cyc(1,0,1,0,0); cyc(0,1,0,0,0); cyc(0,0,1,0,0); idle(1);
    // expiry from 00:00:02
    rst_v = 0; idle(1); rst_v = 1;
    cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,0,0,1,0); cyc(0,0,0,1,0);
    cyc(0,0,1,0,0); cyc(0,1,0,0,0);
    cyc(1,0,0,0,0); idle(1); cyc(1,0,0,0,0);
    for (int i = 0; i < DONE_SECONDS + 2; i++) begin cyc(1,0,0,0,0); idle(1); end
    cyc(0,1,0,0,0); cyc(1,0,0,0,0); cyc(1,0,0,0,0); idle(2); cyc(0,1,0,0,0); idle(1);
    // active=0: buttons ignored, ticks still count
    cyc(0,1,0,0,0); act_v = 0;
    cyc(0,0,1,0,0); cyc(0,1,0,0,0); cyc(1,1,1,0,0); cyc(1,0,0,1,1);
    act_v = 1; cyc(0,1,0,0,0); idle(1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_v = ($urandom_range(0, 499) != 0);
      act_v = ($urandom_range(0, 9) != 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    rst_v = 1; act_v = 1; idle(2);
    repeat (3) @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
